// File: rtl/faccel_param.sv
// Parametrised iterative factorial accelerator.
// Register window N/G/S/F with overflow flag, busy and done pulse.
module faccel_param #(
  parameter int NW = 4,
  parameter int RW = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          wel,
  input  logic [1:0]    a,
  input  logic [NW-1:0] d,
  output logic [RW-1:0] out,
  output logic          done_p
);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DONE,
    ERR
  } state_t;

  state_t state, state_nx;

  logic [NW-1:0]    n, n_nx;
  logic [NW-1:0]    cnt, cnt_nx;
  logic             g, g_nx;
  logic [RW-1:0]    prod, prod_nx;
  logic [RW-1:0]    f, f_nx;
  logic             done, done_nx;
  logic             err, err_nx;
  logic             dp_nx;
  logic             busy;
  logic [RW+NW-1:0] wide;

  assign busy = (state == MULT);

  // full-width step product; upper NW bits flag overflow
  always_comb begin
    wide = (RW+NW)'(prod) * (RW+NW)'(cnt);
  end

  // next-state: one multiply step per cycle, writes only when not busy
  always_comb begin
    state_nx = state;
    n_nx     = n;
    cnt_nx   = cnt;
    g_nx     = g;
    prod_nx  = prod;
    f_nx     = f;
    done_nx  = done;
    err_nx   = err;
    dp_nx    = 1'b0;
    unique case (state)
      MULT: begin
        if (cnt <= NW'(1)) begin
          f_nx     = prod;
          done_nx  = 1'b1;
          dp_nx    = 1'b1;
          state_nx = DONE;
        end else if (wide[RW+NW-1:RW] != '0) begin
          f_nx     = '0;
          err_nx   = 1'b1;
          dp_nx    = 1'b1;
          state_nx = ERR;
        end else begin
          prod_nx = wide[RW-1:0];
          cnt_nx  = cnt - NW'(1);
        end
      end
      default: begin
        if (wel) begin
          case (a)
            2'd0: n_nx = d;
            2'd1: begin
              g_nx = d[0];
              if (d[0]) begin
                cnt_nx   = n;
                prod_nx  = RW'(1);
                done_nx  = 1'b0;
                err_nx   = 1'b0;
                state_nx = MULT;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // state and register file update; reset aborts any computation
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      n      <= '0;
      cnt    <= '0;
      g      <= 1'b0;
      prod   <= '0;
      f      <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      done_p <= 1'b0;
    end else begin
      state  <= state_nx;
      n      <= n_nx;
      cnt    <= cnt_nx;
      g      <= g_nx;
      prod   <= prod_nx;
      f      <= f_nx;
      done   <= done_nx;
      err    <= err_nx;
      done_p <= dp_nx;
    end
  end

  // read mux, zero-extended
  always_comb begin
    case (a)
      2'd0:    out = RW'(n);
      2'd1:    out = RW'(g);
      2'd2:    out = RW'({busy, err, done});
      default: out = f;
    endcase
  end

endmodule

// File: doc/faccel_param.md
Name: faccel_param

Overview:
Parametrised iterative factorial accelerator. It is memory-mapped through a 4-entry register window: N (operand), G (go), S (status) and F (result). It is the generalised successor to the fixed 4-bit/32-bit factorial accelerator. It adds configurable operand and result widths, overflow detection with an error flag, a busy indication, a done pulse output, and write protection while busy. It sits on the pipelined processor's peripheral bus as a slave.

Parameters:
NW, 4, operand width in bits; the d input and the N register are NW bits.
RW, 32, result width in bits; the out port and the F register are RW bits.

Ports:
Clk  in  1  clock; all state updates on the rising edge.
Rst  in  1  synchronous, active-high reset.
wel  in  1  write enable for the register selected by a.
a  in  2  register address: 0=N, 1=G, 2=S, 3=F.
d  in  NW  write data.
out  out  RW  read data for address a; combinational mux, zero-extended.
done_p  out  1  one-cycle pulse on entry to DONE or ERR.

Behaviour:
- Reset (Rst=1 at an edge): N=0, G=0, cnt=0, prod=0, F=0, done=0, err=0, state=IDLE, done_p=0.
- Reset mid-computation aborts the computation immediately; no result is written.
- FSM states: IDLE, MULT, DONE, ERR.
- busy = (state==MULT).
- Register reads, selected by a:
  - a=0: N, zero-extended.
  - a=1: {0, G}.
  - a=2: {0, busy, err, done} (bit2=busy, bit1=err, bit0=done).
  - a=3: F.
- Write to N: if wel=1, a=0 and not busy, N <= d. Ignored while busy.
- Write to G: if wel=1, a=1 and not busy, G <= d[0]. If d[0]=1 this is also the start edge.
  - Start edge actions: cnt <= N, prod <= 1, done <= 0, err <= 0, F unchanged, state <= MULT.
- Writes to G while busy are ignored; G, state and the counter are untouched.
- Writes to S or F have no effect.
- MULT, one step per cycle:
  - If cnt <= 1: F <= prod, done <= 1, state <= DONE, done_p = 1 for that one cycle.
  - Else: compute wide = prod * cnt at RW+NW bits.
    - If wide[RW+NW-1:RW] != 0: F <= 0, err <= 1, state <= ERR, done_p pulses.
    - Otherwise: prod <= wide[RW-1:0], cnt <= cnt - 1.
- Latency: for a start edge E0, done is visible after edge E0 + max(N,1) when no overflow occurs.
  - N=0 and N=1 both give F=1 after 1 cycle.
- DONE and ERR are held until the next start edge; they accept new N writes and a G start.
- IDLE behaves like DONE except that done=0.
- G is not auto-cleared. It reads back the last accepted value.
- Simultaneous Rst and wel: reset wins.
- A single cycle carries only one write, since there is one address.

Test Plan:
- Rst; write N=5; write G=1; poll S until bit0=1 -> exactly 5 cycles after the G edge, F=120, S=3'b001, done_p high for 1 cycle, N reads 5, G reads 1.
- N=0, then N=1, each started with G=1 -> F=1 after 1 cycle, err=0.
- NW=4, RW=32: N=12 -> F=479001600, err=0. N=13 -> S=3'b010, F=0, done_p pulses, busy drops.
- Start N=6; during MULT write N=3 and G=1 -> both ignored, S bit2=1 while running, final F=720, N reads 6.
- Start N=9; assert Rst on the 3rd busy cycle -> next cycle all registers read 0, S=0, no done_p. Then start N=4 -> F=24.
- After DONE with F=120, write N=3 and G=1 -> done clears on the start edge, F holds 120 until F=6 lands 3 cycles later.
